amo_sequencer: RTL and testbench
================================

# amo_sequencer

Read-modify-write sequencer for one core's RISC-V AMO instructions. It accepts an AMO request from the load/store unit and locks the shared bus against the other core. It then reads the target word, presents the loaded value, rs2 and op to the downstream AMO ALU, writes the ALU result back, releases the lock and returns the original memory value as the instruction's rd result. It is the control stage that directly feeds the combinational AMO ALU and consumes its result.

## Interface
- ID_W, default 3, width of the request/response tag
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low)
- req_valid  in  1  AMO request valid
- req_ready  out  1  sequencer can accept a request
- req_addr  in  32  word address (bits [1:0] ignored, driven as 0 on memory ports)
- req_rs2  in  32  rs2 operand
- req_op  in  5  AMO funct5 code, passed unmodified to ALU
- req_id  in  ID_W  tag returned with response
- lock_req  out  1  request exclusive ownership of shared memory bus
- lock_gnt  in  1  ownership granted; arbiter holds it while lock_req stays high
- rd_req_valid  out  1  read request; rd_req_ready  in  1  read accepted
- rd_addr  out  32  read address
- rd_resp_valid  in  1  read data valid; rd_resp_data  in  32  read data
- wr_req_valid  out  1  write request; wr_req_ready  in  1  write accepted
- wr_addr  out  32  write address; wr_data  out  32  write data (= alu_result)
- alu_op  out  5  to ALU op; alu_rs1_load  out  32  loaded value; alu_rs2  out  32  rs2
- alu_result  in  32  combinational result from ALU
- done_valid  out  1  response valid; done_ready  in  1  response consumed
- done_data  out  32  original memory value (rd); done_id  out  ID_W  tag
- busy  out  1  high in any state other than IDLE

## Operation
- Registers: addr_r, rs2_r, op_r, id_r, load_r, state.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, capture the req_* fields, then go to LOCK.
  - LOCK: lock_req=1. On lock_gnt, go to RD_REQ.
  - RD_REQ: rd_req_valid=1, rd_addr={addr_r[31:2],2'b00}. On rd_req_ready, go to RD_WAIT.
  - RD_WAIT: on rd_resp_valid, load_r<=rd_resp_data, then go to WR.
  - WR: wr_req_valid=1, wr_addr=rd_addr value, wr_data=alu_result. On wr_req_ready, go to RESP.
  - RESP: done_valid=1, done_data=load_r, done_id=id_r. On done_ready, go to IDLE.
- lock_req is high in LOCK, RD_REQ, RD_WAIT and WR. It drops in the cycle after write acceptance, so the lock never spans the response handshake.
- ALU outputs are driven continuously: alu_op=op_r, alu_rs1_load=load_r, alu_rs2=rs2_r. wr_data is purely combinational from the ALU during WR; no result register.
- Opcodes are not decoded. An unsupported op writes whatever the ALU returns (0 for unused codes).
- rd_resp_valid outside RD_WAIT is ignored. lock_gnt outside LOCK is ignored for transitions.
- req_ready is low in all states except IDLE. One AMO is in flight at a time.
- All valid outputs, once raised, hold with stable payload until their ready is seen.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE. req_ready=1. lock_req, rd_req_valid, wr_req_valid, done_valid and busy are 0. All data/address/id outputs and registers are 0.
- Reset mid-operation: immediate return to IDLE with lock_req low. The in-flight AMO is dropped and produces no write or response.
- Best-case latency, with lock_gnt, rd_req_ready, wr_req_ready and done_ready tied high and rd_resp_valid arriving one cycle after read acceptance:
  - accept at edge 0, LOCK in cycle 1, RD_REQ in cycle 2, RD_WAIT in cycle 3, WR in cycle 4, RESP in cycle 5.
  - done_valid is high 5 cycles after acceptance; req_ready returns in cycle 6.
- Each stall (no grant, no ready, no response) adds exactly one cycle per stalled cycle. There is no timeout.
- Back-to-back: next request accepted earliest the cycle after done handshake (IDLE).

## Test plan
- AMOADD (funct5 00000): mem[0x100]=5, rs2=3, all readies high. Required: write 8 to 0x100; done_data=5; done_valid exactly 5 cycles after acceptance; id echoed.
- AMOSWAP (00001): mem[0x204]=0xDEADBEEF, rs2=0x12345678, wr_req_ready low 4 cycles. Required: wr_data and wr_addr stable throughout the stall; write 0x12345678; done_data=0xDEADBEEF; done_valid 9 cycles after acceptance.
- Lock contention: lock_gnt held low 10 cycles. Required: lock_req high the whole time, no rd_req_valid before grant, and lock_req drops the cycle after write acceptance.
- Unaligned address 0x103, AMOXOR (00100), mem=0xFF, rs2=0x0F. Required: rd_addr=wr_addr=0x100, write 0xF0.
- Reset asserted while in RD_WAIT. Required: the same cycle shows lock_req=0 and busy=0, and no write or done occurs. A stray rd_resp_valid after reset is ignored and the next AMO completes correctly.
- Two requests presented back-to-back with done_ready delayed 3 cycles. Required: the second is not accepted until the cycle after the first done handshake; both responses are correct and in order.

Source files
------------

// File: rtl/amo_sequencer.sv
// Read-modify-write sequencer for RISC-V AMOs: lock the shared bus, read the word,
// write back the external ALU result, release the lock, then return the old value.
module amo_sequencer #(
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_rs2,
    input  logic [4:0]      req_op,
    input  logic [ID_W-1:0] req_id,
    output logic            lock_req,
    input  logic            lock_gnt,
    output logic            rd_req_valid,
    input  logic            rd_req_ready,
    output logic [31:0]     rd_addr,
    input  logic            rd_resp_valid,
    input  logic [31:0]     rd_resp_data,
    output logic            wr_req_valid,
    input  logic            wr_req_ready,
    output logic [31:0]     wr_addr,
    output logic [31:0]     wr_data,
    output logic [4:0]      alu_op,
    output logic [31:0]     alu_rs1_load,
    output logic [31:0]     alu_rs2,
    input  logic [31:0]     alu_result,
    output logic            done_valid,
    input  logic            done_ready,
    output logic [31:0]     done_data,
    output logic [ID_W-1:0] done_id,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOCK    = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_WR      = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t          state_q;
    logic [31:0]     addr_q;
    logic [31:0]     rs2_q;
    logic [4:0]      op_q;
    logic [ID_W-1:0] id_q;
    logic [31:0]     load_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rs2_q   <= '0;
            op_q    <= '0;
            id_q    <= '0;
            load_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        // Word-align once at capture so both memory ports share one address.
                        addr_q  <= req_addr & ~32'h0000_0003;
                        rs2_q   <= req_rs2;
                        op_q    <= req_op;
                        id_q    <= req_id;
                        state_q <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (lock_gnt) state_q <= S_RD_REQ;
                end
                S_RD_REQ: begin
                    if (rd_req_ready) state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (rd_resp_valid) begin
                        load_q  <= rd_resp_data;
                        state_q <= S_WR;
                    end
                end
                S_WR: begin
                    if (wr_req_ready) state_q <= S_RESP;
                end
                S_RESP: begin
                    if (done_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // All handshake outputs decode straight from the state register.
    assign req_ready    = (state_q == S_IDLE);
    assign lock_req     = (state_q == S_LOCK) || (state_q == S_RD_REQ) ||
                          (state_q == S_RD_WAIT) || (state_q == S_WR);
    assign rd_req_valid = (state_q == S_RD_REQ);
    assign wr_req_valid = (state_q == S_WR);
    assign done_valid   = (state_q == S_RESP);
    assign busy         = (state_q != S_IDLE);

    assign rd_addr      = addr_q;
    assign wr_addr      = addr_q;
    assign wr_data      = (state_q == S_WR) ? alu_result : 32'd0;

    assign alu_op       = op_q;
    assign alu_rs1_load = load_q;
    assign alu_rs2      = rs2_q;

    assign done_data    = load_q;
    assign done_id      = id_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// Bench for amo_sequencer: a bus/memory responder and ALU model around the DUT,
// table vectors, hand-written corner sequences and randomized AMOs against a model.
module tb_amo_sequencer;
    localparam int ID_W = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_addr;
    logic [31:0]     req_rs2;
    logic [4:0]      req_op;
    logic [ID_W-1:0] req_id;
    logic            lock_req;
    logic            lock_gnt;
    logic            rd_req_valid;
    logic            rd_req_ready;
    logic [31:0]     rd_addr;
    logic            rd_resp_valid;
    logic [31:0]     rd_resp_data;
    logic            wr_req_valid;
    logic            wr_req_ready;
    logic [31:0]     wr_addr;
    logic [31:0]     wr_data;
    logic [4:0]      alu_op;
    logic [31:0]     alu_rs1_load;
    logic [31:0]     alu_rs2;
    logic [31:0]     alu_result;
    logic            done_valid;
    logic            done_ready;
    logic [31:0]     done_data;
    logic [ID_W-1:0] done_id;
    logic            busy;

    amo_sequencer #(.ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_rs2(req_rs2), .req_op(req_op), .req_id(req_id),
        .lock_req(lock_req), .lock_gnt(lock_gnt),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_op(alu_op), .alu_rs1_load(alu_rs1_load), .alu_rs2(alu_rs2),
        .alu_result(alu_result),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_data(done_data), .done_id(done_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // RISC-V AMO semantics; unused codes give 0.
    function automatic logic [31:0] amo_fn(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            5'b00000: return a + b;
            5'b00001: return b;
            5'b00100: return a ^ b;
            5'b01000: return a | b;
            5'b01100: return a & b;
            5'b10000: return ($signed(a) < $signed(b)) ? a : b;
            5'b10100: return ($signed(a) > $signed(b)) ? a : b;
            5'b11000: return (a < b) ? a : b;
            5'b11100: return (a > b) ? a : b;
            default:  return 32'd0;
        endcase
    endfunction

    assign alu_result = amo_fn(alu_op, alu_rs1_load, alu_rs2);

    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'd0;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0]     addr;
        logic [31:0]     rs2;
        logic [4:0]      op;
        logic [ID_W-1:0] id;
        int              gnt_st;
        int              rdr_st;
        int              resp_dly;
        int              wr_st;
        int              done_st;
    } amo_t;

    typedef struct {
        int              lat;
        int              wrote;
        logic [31:0]     wa;
        logic [31:0]     wd;
        logic [31:0]     rda;
        logic [31:0]     dd;
        logic [ID_W-1:0] did;
        int              errs;
        bit              lock_drop_ok;
        bit              timeout;
        bit              aborted;
        int              acc_wait;
    } res_t;

    typedef struct {
        amo_t        t;
        logic [31:0] init;
        logic [31:0] exp_wa;
        logic [31:0] exp_wd;
        logic [31:0] exp_dd;
        int          exp_lat;
    } vec_t;

    function automatic amo_t mk_amo(input logic [31:0] addr, input logic [31:0] rs2,
                                    input logic [4:0] op, input int id, input int gnt,
                                    input int rdr, input int dly, input int wr, input int dn);
        amo_t t;
        t.addr = addr; t.rs2 = rs2; t.op = op; t.id = ID_W'(id);
        t.gnt_st = gnt; t.rdr_st = rdr; t.resp_dly = dly; t.wr_st = wr; t.done_st = dn;
        return t;
    endfunction

    function automatic vec_t mk_vec(input amo_t t, input logic [31:0] init,
                                    input logic [31:0] ewa, input logic [31:0] ewd,
                                    input logic [31:0] edd, input int elat);
        vec_t v;
        v.t = t; v.init = init; v.exp_wa = ewa; v.exp_wd = ewd; v.exp_dd = edd;
        v.exp_lat = elat;
        return v;
    endfunction

    // Plays requester, arbiter, memory and response sink for one AMO.
    task automatic do_amo(input amo_t t, input bit hold, input amo_t nt, input bit abort,
                          output res_t r);
        int gw = 0, rw = 0, ww = 0, dw = 0, rd_cnt = 0, cyc = 0;
        bit granted = 0, rd_pend = 0, rd_acc = 0, wr_seen = 0, wr_acc = 0;
        bit dn_seen = 0, check_drop = 0, fin = 0;
        logic [31:0] rd_val = '0;
        r = '{default: 0};
        @(negedge clk);
        lock_gnt = 0; rd_req_ready = 0; wr_req_ready = 0; done_ready = 0; rd_resp_valid = 0;
        req_valid = 1; req_addr = t.addr; req_rs2 = t.rs2; req_op = t.op; req_id = t.id;
        while (!req_ready) begin
            if (r.acc_wait > 50) begin
                r.timeout = 1;
                req_valid = 0;
                return;
            end
            @(negedge clk);
            r.acc_wait++;
        end
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                req_valid = 1; req_addr = nt.addr; req_rs2 = nt.rs2; req_op = nt.op; req_id = nt.id;
            end else begin
                req_valid = 0;
            end
            if (req_ready || !busy) r.errs++;
            if (check_drop) begin
                r.lock_drop_ok = !lock_req;
                check_drop = 0;
            end else if (wr_acc && lock_req) begin
                r.errs++;
            end else if (!wr_acc && !lock_req) begin
                r.errs++;
            end
            if (rd_req_valid && !granted) r.errs++;
            if (lock_req && !wr_acc) begin
                if (gw < t.gnt_st) begin
                    lock_gnt = 0; gw++;
                end else begin
                    lock_gnt = 1; granted = 1;
                end
            end else begin
                lock_gnt = 0;
            end
            rd_resp_valid = 0;
            if (rd_pend) begin
                if (abort) begin
                    r.aborted = 1;
                    req_valid = 0; lock_gnt = 0;
                    return;
                end
                if (rd_cnt == 0) begin
                    rd_resp_valid = 1; rd_resp_data = rd_val; rd_pend = 0;
                end else begin
                    rd_cnt--;
                end
            end
            rd_req_ready = 0;
            if (rd_req_valid) begin
                if (rd_acc) r.errs++;
                if (rw == 0 && r.rda === 32'd0 && !rd_acc) r.rda = rd_addr;
                else if (rd_addr !== r.rda) r.errs++;
                if (rw < t.rdr_st) begin
                    rw++;
                end else if (!rd_acc) begin
                    rd_req_ready = 1; rd_acc = 1; rd_pend = 1;
                    rd_cnt = t.resp_dly; rd_val = mem_rd(rd_addr);
                end
            end
            wr_req_ready = 0;
            if (wr_req_valid) begin
                if (!wr_seen) begin
                    wr_seen = 1; r.wa = wr_addr; r.wd = wr_data;
                end else if (wr_addr !== r.wa || wr_data !== r.wd) begin
                    r.errs++;
                end
                if (ww < t.wr_st) begin
                    ww++;
                end else begin
                    wr_req_ready = 1; mem[wr_addr] = wr_data; r.wrote++;
                    wr_acc = 1; check_drop = 1;
                end
            end
            done_ready = 0;
            if (done_valid) begin
                if (!dn_seen) begin
                    dn_seen = 1; r.lat = cyc; r.dd = done_data; r.did = done_id;
                end else if (done_data !== r.dd || done_id !== r.did) begin
                    r.errs++;
                end
                if (dw < t.done_st) begin
                    dw++;
                end else begin
                    done_ready = 1; fin = 1;
                end
            end
        end
        if (!fin) r.timeout = 1;
    endtask

    task automatic check_res(input string tag, input res_t r, input logic [ID_W-1:0] id,
                             input logic [31:0] ewa, input logic [31:0] ewd,
                             input logic [31:0] edd, input int elat);
        chk({tag, " timeout"}, 32'(r.timeout), 32'd0);
        chk({tag, " rd_addr"}, r.rda, ewa);
        chk({tag, " wr_addr"}, r.wa, ewa);
        chk({tag, " wr_data"}, r.wd, ewd);
        chk({tag, " writes"}, 32'(r.wrote), 32'd1);
        chk({tag, " done_data"}, r.dd, edd);
        chk({tag, " done_id"}, 32'(r.did), 32'(id));
        chk({tag, " latency"}, 32'(r.lat), 32'(elat));
        chk({tag, " protocol"}, 32'(r.errs), 32'd0);
        chk({tag, " lock_drop"}, 32'(r.lock_drop_ok), 32'd1);
    endtask

    vec_t vt[7];
    logic [4:0] ops[10];

    initial begin
        res_t r, r2;
        amo_t a, b;
        int bad_cnt;
        rst_n = 0; req_valid = 0; req_addr = 0; req_rs2 = 0; req_op = 0; req_id = 0;
        lock_gnt = 0; rd_req_ready = 0; rd_resp_valid = 0; rd_resp_data = 0;
        wr_req_ready = 0; done_ready = 0;

        vt[0] = mk_vec(mk_amo(32'h100, 32'd3, 5'b00000, 1, 0, 0, 0, 0, 0),
                       32'd5, 32'h100, 32'd8, 32'd5, 5);
        vt[1] = mk_vec(mk_amo(32'h204, 32'h12345678, 5'b00001, 2, 0, 0, 0, 4, 0),
                       32'hDEADBEEF, 32'h204, 32'h12345678, 32'hDEADBEEF, 9);
        vt[2] = mk_vec(mk_amo(32'h300, 32'h0F, 5'b01000, 3, 10, 0, 0, 0, 0),
                       32'hF0, 32'h300, 32'hFF, 32'hF0, 15);
        vt[3] = mk_vec(mk_amo(32'h103, 32'h0F, 5'b00100, 4, 0, 0, 0, 0, 0),
                       32'hFF, 32'h100, 32'hF0, 32'hFF, 5);
        vt[4] = mk_vec(mk_amo(32'h40, 32'd9, 5'b11000, 5, 0, 0, 2, 0, 0),
                       32'd7, 32'h40, 32'd7, 32'd7, 7);
        vt[5] = mk_vec(mk_amo(32'h44, 32'h1234, 5'b00010, 6, 0, 0, 0, 0, 2),
                       32'h55, 32'h44, 32'd0, 32'h55, 5);
        vt[6] = mk_vec(mk_amo(32'h48, 32'd1, 5'b10100, 7, 0, 1, 0, 0, 0),
                       32'hFFFFFFFE, 32'h48, 32'd1, 32'hFFFFFFFE, 6);

        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset lock_req", 32'(lock_req), 32'd0);
        chk("reset valids", {28'd0, rd_req_valid, wr_req_valid, done_valid, busy}, 32'd0);
        chk("reset addrs", rd_addr | wr_addr | wr_data, 32'd0);
        chk("reset done", done_data | 32'(done_id), 32'd0);
        chk("reset alu", alu_rs1_load | alu_rs2 | 32'(alu_op), 32'd0);
        rst_n = 1;

        foreach (vt[i]) begin
            mem[vt[i].t.addr & ~32'h3] = vt[i].init;
            do_amo(vt[i].t, 1'b0, vt[i].t, 1'b0, r);
            $display("vec %0d: op=%b addr=%h wr=%h done=%h lat=%0d", i, vt[i].t.op,
                     vt[i].t.addr, r.wd, r.dd, r.lat);
            check_res($sformatf("vec%0d", i), r, vt[i].t.id, vt[i].exp_wa, vt[i].exp_wd,
                      vt[i].exp_dd, vt[i].exp_lat);
        end

        // Reset while waiting for read data: AMO must vanish with no write or response.
        mem[32'h80] = 32'h10;
        a = mk_amo(32'h80, 32'd1, 5'b00000, 2, 0, 0, 0, 0, 0);
        do_amo(a, 1'b0, a, 1'b1, r);
        chk("abort reached RD_WAIT", 32'(r.aborted), 32'd1);
        rst_n = 0;
        #1;
        chk("abort lock_req", 32'(lock_req), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1;
        rd_resp_valid = 1; rd_resp_data = 32'hBAD0BAD0;
        bad_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            rd_resp_valid = 0;
            if (wr_req_valid || done_valid || busy) bad_cnt++;
        end
        $display("reset-abort: stray-response activity cycles=%0d", bad_cnt);
        chk("abort quiet", 32'(bad_cnt), 32'd0);
        chk("abort mem untouched", mem_rd(32'h80), 32'h10);
        do_amo(a, 1'b0, a, 1'b0, r);
        $display("post-reset: wr=%h done=%h lat=%0d", r.wd, r.dd, r.lat);
        check_res("post-reset", r, a.id, 32'h80, 32'h11, 32'h10, 5);

        // Back-to-back with the second request held valid during the first.
        mem[32'h500] = 32'd1;
        mem[32'h504] = 32'hF0F0;
        a = mk_amo(32'h500, 32'd2, 5'b00000, 5, 0, 0, 0, 0, 3);
        b = mk_amo(32'h504, 32'hFF, 5'b01100, 6, 0, 0, 0, 0, 0);
        do_amo(a, 1'b1, b, 1'b0, r);
        do_amo(b, 1'b0, b, 1'b0, r2);
        $display("b2b: first done=%h id=%0d, second done=%h id=%0d wait=%0d", r.dd, r.did,
                 r2.dd, r2.did, r2.acc_wait);
        check_res("b2b first", r, a.id, 32'h500, 32'd3, 32'd1, 5);
        check_res("b2b second", r2, b.id, 32'h504, 32'hF0, 32'hF0F0, 5);
        chk("b2b accept wait", 32'(r2.acc_wait), 32'd0);

        // Randomized AMOs against a word-level memory model.
        ops = '{5'b00000, 5'b00001, 5'b00100, 5'b01000, 5'b01100,
                5'b10000, 5'b10100, 5'b11000, 5'b11100, 5'b00011};
        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            v = $urandom;
            mem[32'h1000 + 32'(4 * i)] = v;
            ref_mem[32'h1000 + 32'(4 * i)] = v;
        end
        for (int n = 0; n < 40; n++) begin
            logic [31:0] wa, old_v, new_v;
            int elat;
            a = mk_amo(32'h1000 + 32'($urandom_range(0, 31)), $urandom,
                       ops[$urandom_range(0, 9)], int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)));
            wa = a.addr & ~32'h3;
            old_v = ref_mem[wa];
            new_v = amo_fn(a.op, old_v, a.rs2);
            ref_mem[wa] = new_v;
            elat = 5 + a.gnt_st + a.rdr_st + a.resp_dly + a.wr_st;
            do_amo(a, 1'b0, a, 1'b0, r);
            $display("rand %0d: op=%b addr=%h rs2=%h wr=%h done=%h lat=%0d", n, a.op,
                     a.addr, a.rs2, r.wd, r.dd, r.lat);
            check_res($sformatf("rand%0d", n), r, a.id, wa, new_v, old_v, elat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
